conv_mac_engine: RTL and testbench

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

---
 rtl/conv_mac_engine.sv | 80 ++++++++
 tb/tb_conv_mac_engine.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: sequential KxK window engine -- MAC convolution (optional ReLU) or max-pool,
// one tap per cycle over a latched operand window, saturated signed result.
module conv_mac_engine #(
   parameter int N = 8,
   parameter int K = 3,
   parameter int SHIFT = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [K*K*N-1:0] pix_in,
   input  logic [K*K*N-1:0] fil_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [N-1:0]     result
);
   localparam int T = K * K;
   localparam int ACCW = 2 * N + $clog2(T);
   localparam int IW = (T > 1) ? $clog2(T) : 1;
   localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [ACCW-1:0] MINV = {{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [T*N-1:0] pix_q, fil_q;
   logic [1:0] mode_q;
   logic [IW-1:0] idx;
   logic signed [ACCW-1:0] acc, acc_next, ext_p, ext_prod, sh;
   logic signed [N-1:0] p, f, sat, res_n, result_q;
   logic signed [2*N-1:0] prod;
   logic last, accept;
   assign p = pix_q[idx*N +: N];
   assign f = fil_q[idx*N +: N];
   assign prod = p * f;
   assign ext_p = ACCW'(p);
   assign ext_prod = ACCW'(prod);
   assign last = idx == IW'(T - 1);
   assign accept = state == IDLE && start;
   assign result = result_q;
   // Max-pool seeds the running maximum with tap 0 instead of the cleared accumulator.
   always_comb begin
      acc_next = mode_q == 2'b10 ? ((idx == '0 || ext_p > acc) ? ext_p : acc) : acc + ext_prod;
      sh = acc_next >>> SHIFT;
      sat = sh > MAXV ? MAXV[N-1:0] : sh < MINV ? MINV[N-1:0] : sh[N-1:0];
      res_n = mode_q == 2'b11 ? '0 : mode_q == 2'b10 ? acc_next[N-1:0] : (mode_q == 2'b01 && sat[N-1]) ? '0 : sat;
   end
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
   end
   always_comb begin
      busy = state != IDLE;
      done = state == DONE;
      err = state == DONE && mode_q == 2'b11;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         pix_q <= '0;
         fil_q <= '0;
         mode_q <= '0;
         acc <= '0;
         idx <= '0;
         result_q <= '0;
      end else if (accept) begin
         pix_q <= pix_in;
         fil_q <= fil_in;
         mode_q <= mode;
         acc <= '0;
         idx <= '0;
      end else if (state == RUN) begin
         acc <= acc_next;
         idx <= last ? idx : idx + 1'b1;
         if (last) result_q <= res_n;
      end
   end
endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: directed checks of conv, saturation, ReLU, max-pool, reserved mode,
// ignored starts, mid-run reset and start-after-reset for the default 3x3, 8-bit engine.
module tb_conv_mac_engine;
   localparam int N = 8;
   localparam int K = 3;
   localparam int T = K * K;
   logic clock = 1'b0;
   logic reset, start;
   logic [1:0] mode;
   logic [T*N-1:0] pix_in, fil_in;
   logic busy, done, err;
   logic [N-1:0] result;
   int checks = 0;
   int errors = 0;
   int mp[T] = '{-5, 3, -128, 0, 1, 2, -1, 4, 7};
   always #5 clock = ~clock;
   conv_mac_engine #(.N(N), .K(K), .SHIFT(0)) dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode),
      .pix_in(pix_in), .fil_in(fil_in),
      .busy(busy), .done(done), .err(err), .result(result)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic fill(input logic [N-1:0] pv, input logic [N-1:0] fv);
      pix_in = {T{pv}};
      fil_in = {T{fv}};
   endtask
   task automatic scramble();
      for (int i = 0; i < T; i++) begin
         pix_in[i*N +: N] = N'($urandom);
         fil_in[i*N +: N] = N'($urandom);
      end
      mode = 2'($urandom);
   endtask
   // Start one operation, disturb the inputs while it runs, then check timing and outcome.
   task automatic run(input logic [1:0] m, input logic [N-1:0] exp_res, input logic exp_err, input string tag);
      int cyc;
      logic busy_ok;
      @(negedge clock);
      mode = m;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      scramble();
      cyc = 1;
      busy_ok = 1'b1;
      while (!done && cyc < 20) begin
         busy_ok &= busy;
         @(negedge clock);
         cyc++;
      end
      chk({tag, "_latency"}, cyc, 10);
      chk({tag, "_busy_run"}, busy_ok, 1);
      chk({tag, "_busy_done"}, busy, 1);
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_err"}, err, exp_err);
      @(negedge clock);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_err_low"}, err, 0);
      chk({tag, "_held"}, result, exp_res);
   endtask
   initial begin
      int seen, cyc;
      reset = 1'b1;
      start = 1'b0;
      mode = 2'b00;
      fill('0, '0);
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_result", result, 0);
      reset = 1'b0;
      fill(8'd1, 8'd1);
      run(2'b00, 8'h09, 1'b0, "conv_ones");
      fill(8'd127, 8'd127);
      run(2'b00, 8'h7F, 1'b0, "sat_pos");
      fill(8'h80, 8'd127);
      run(2'b00, 8'h80, 1'b0, "sat_neg");
      fill(8'hFF, 8'd1);
      run(2'b00, 8'hF7, 1'b0, "conv_neg");
      fill(8'hFF, 8'd1);
      run(2'b01, 8'h00, 1'b0, "relu");
      for (int i = 0; i < T; i++) begin
         pix_in[i*N +: N] = N'(mp[i]);
         fil_in[i*N +: N] = N'($urandom);
      end
      run(2'b10, 8'h07, 1'b0, "maxpool");
      fill(8'h80, 8'h55);
      run(2'b10, 8'h80, 1'b0, "maxpool_min");
      for (int i = 0; i < T; i++) begin
         pix_in[i*N +: N] = N'(i + 1);
         fil_in[i*N +: N] = (i % 2 == 0) ? 8'd2 : 8'hFF;
      end
      run(2'b00, 8'h1E, 1'b0, "conv_mixed");
      fill(8'd5, 8'd5);
      run(2'b11, 8'h00, 1'b1, "reserved");
      @(negedge clock);
      fill(8'd1, 8'd1);
      mode = 2'b00;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      fill(8'd9, 8'd9);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      seen = 0;
      repeat (25) begin
         @(negedge clock);
         seen += int'(done);
      end
      chk("ignored_start_dones", seen, 1);
      chk("ignored_start_result", result, 8'h09);
      chk("ignored_start_idle", busy, 0);
      fill(8'd3, 8'd3);
      mode = 2'b00;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      seen = 0;
      repeat (15) begin
         @(negedge clock);
         seen += int'(done);
      end
      chk("midrst_no_done", seen, 0);
      fill(8'd1, 8'd1);
      run(2'b00, 8'h09, 1'b0, "after_rst");
      reset = 1'b1;
      start = 1'b1;
      mode = 2'b00;
      fill(8'd2, 8'd3);
      @(negedge clock);
      chk("rst_over_start", busy, 0);
      reset = 1'b0;
      @(negedge clock);
      chk("start_after_rst", busy, 1);
      start = 1'b0;
      scramble();
      cyc = 1;
      while (!done && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      chk("start_after_rst_latency", cyc, 10);
      chk("start_after_rst_result", result, 8'h36);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
